// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared types and segment table for the seven-segment scan driver
package ssd_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic [3:0] AN_OFF  = 4'h0;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/ssd_scan_driver_if.sv
// rtl/ssd_scan_driver_if.sv - digit inputs and display outputs of the scan driver
interface ssd_scan_driver_if;

    logic       en;
    logic [3:0] R3;
    logic [3:0] R2;
    logic [3:0] R1;
    logic [3:0] R0;
    logic [3:0] dp_mask;
    logic       blank_lz;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output en, R3, R2, R1, R0, dp_mask, blank_lz,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  en, R3, R2, R1, R0, dp_mask, blank_lz,
        output an, seg, dp, frame_tick
    );

endinterface

// File: rtl/ssd_decoder.sv
// rtl/ssd_decoder.sv - combinational hex to seven-segment decode, active-high
module ssd_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - time-multiplexed 4-digit seven-segment driver with frame-aligned digit snapshot
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    ssd_scan_driver_if.slave    bus
);

    localparam int DIVISOR = (CLK_HZ / SCAN_HZ < 1) ? 1 : CLK_HZ / SCAN_HZ;
    localparam int CW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);
    localparam logic POL   = (ACTIVE_LOW != 0);

    logic [CW-1:0]   count;
    digit_idx_t      sel;
    logic [3:0][3:0] sh_digit;
    logic [3:0]      sh_dp;
    logic            sh_blz;
    logic            load_pending;

    logic            tick;
    logic            boundary;
    logic            load;
    logic [3:0]      blank;
    logic [3:0]      cur_digit;
    logic [6:0]      cur_seg;
    logic            show;
    logic [3:0]      an_l;
    logic [6:0]      seg_l;
    logic            dp_l;

    logic [3:0]      an_q;
    logic [6:0]      seg_q;
    logic            dp_q;
    logic            frame_tick_q;

    assign tick     = bus.en && (count == LAST);
    assign boundary = tick && (sel == 2'd3);
    assign load     = bus.en && (boundary || load_pending);

    // Leading zeros blank from the left; the rightmost digit always shows
    always_comb begin
        blank    = 4'b0000;
        blank[3] = sh_blz && (sh_digit[3] == 4'd0);
        blank[2] = blank[3] && (sh_digit[2] == 4'd0);
        blank[1] = blank[2] && (sh_digit[1] == 4'd0);
    end

    assign cur_digit = sh_digit[sel];

    ssd_decoder u_decoder (
        .digit (cur_digit),
        .seg   (cur_seg)
    );

    // Nothing is shown until the first snapshot lands, so reset zeros never reach the display
    always_comb begin
        show  = bus.en && !load_pending && !blank[sel];
        an_l  = AN_OFF;
        seg_l = SEG_OFF;
        dp_l  = 1'b0;
        if (show) begin
            an_l  = 4'b0001 << sel;
            seg_l = cur_seg;
            dp_l  = sh_dp[sel];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            sel          <= '0;
            sh_digit     <= '0;
            sh_dp        <= '0;
            sh_blz       <= 1'b0;
            load_pending <= 1'b1;
            frame_tick_q <= 1'b0;
            an_q         <= AN_OFF ^ {4{POL}};
            seg_q        <= SEG_OFF ^ {7{POL}};
            dp_q         <= POL;
        end else begin
            frame_tick_q <= boundary;
            if (bus.en) begin
                count <= tick ? '0 : count + 1'b1;
                if (tick) begin
                    sel <= sel + 1'b1;
                end
            end
            if (load) begin
                sh_digit     <= {bus.R3, bus.R2, bus.R1, bus.R0};
                sh_dp        <= bus.dp_mask;
                sh_blz       <= bus.blank_lz;
                load_pending <= 1'b0;
            end
            an_q  <= an_l ^ {4{POL}};
            seg_q <= seg_l ^ {7{POL}};
            dp_q  <= dp_l ^ POL;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick_q;

endmodule
